// File: rtl/hamming_rx.sv
// Serial Hamming(7,4) receiver: deserialises MSB-first codewords, corrects any
// single-bit error and presents the nibble on a valid/ready output register.
module hamming_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sync,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic [3:0] out_data,
   output logic [2:0] out_syn,
   output logic       out_corr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] err_cnt
);

   // Handshakes: a bit moves when bit_valid && bit_ready; a word moves when
   // out_valid && out_ready. Producers hold their payload until it moves.

   logic [1:0] rst_sync;
   logic       run;
   logic [5:0] shreg;
   logic [2:0] bit_cnt;
   logic       accept;
   logic       load;
   logic [6:0] word;
   logic [6:0] flip;
   logic [6:0] fixed;
   logic [2:0] syn;

   // Reset asserts immediately but releases two edges later, aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run = rst_sync[1];

   // Only the completing bit is ever stalled, and only by a full, unconsumed slot.
   assign bit_ready = !(bit_cnt == 3'd6 && out_valid && !out_ready);
   assign accept    = bit_valid && bit_ready;
   assign load      = accept && !sync && (bit_cnt == 3'd6);

   // The seventh bit is decoded straight from bit_in, so shreg only needs six bits.
   always_comb begin
      word   = {shreg, bit_in};
      syn[2] = word[6] ^ word[5] ^ word[4] ^ word[3];
      syn[1] = word[6] ^ word[5] ^ word[2] ^ word[1];
      syn[0] = word[6] ^ word[4] ^ word[2] ^ word[0];
      flip   = 7'd0;
      if (syn != 3'd0) flip = 7'd1 << (syn - 3'd1);
      fixed  = word ^ flip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= 6'd0;
         bit_cnt   <= 3'd0;
         out_data  <= 4'd0;
         out_syn   <= 3'd0;
         out_corr  <= 1'b0;
         out_valid <= 1'b0;
         err_cnt   <= 8'd0;
      end else if (!run) begin
         shreg     <= 6'd0;
         bit_cnt   <= 3'd0;
         out_data  <= 4'd0;
         out_syn   <= 3'd0;
         out_corr  <= 1'b0;
         out_valid <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         if (sync) begin
            bit_cnt <= accept ? 3'd1 : 3'd0;
            shreg   <= accept ? {5'd0, bit_in} : 6'd0;
         end else if (accept) begin
            shreg   <= word[5:0];
            bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
         end

         if (load) begin
            out_data  <= {fixed[6], fixed[5], fixed[4], fixed[2]};
            out_syn   <= syn;
            out_corr  <= (syn != 3'd0);
            out_valid <= 1'b1;
            if (syn != 3'd0 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hamming_rx.sv
// Randomised bench for hamming_rx: nearest-codeword reference model, expected
// queue scoreboard with an independent output monitor, plus directed corner cases.
module tb_hamming_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       sync = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_ready;
   logic [3:0] out_data;
   logic [2:0] out_syn;
   logic       out_corr;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] err_cnt;

   hamming_rx dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .out_data(out_data), .out_syn(out_syn), .out_corr(out_corr),
      .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   int          exp_err = 0;
   int          ready_mode = 0;
   bit          gap_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [6:0] enc(input logic [3:0] n);
      logic d3, d2, d1, d0;
      d3 = n[3]; d2 = n[2]; d1 = n[1]; d0 = n[0];
      return {d3, d2, d1, d3 ^ d2 ^ d1, d0, d0 ^ d2 ^ d3, d0 ^ d1 ^ d3};
   endfunction

   // Every 7-bit word lies within distance 1 of exactly one codeword; the
   // syndrome names the differing bit position plus one.
   function automatic logic [7:0] model(input logic [6:0] rx);
      logic [6:0] diff;
      for (int n = 0; n < 16; n++) begin
         diff = enc(n[3:0]) ^ rx;
         if (diff == 7'd0) return {1'b0, 3'd0, n[3:0]};
         if ($countones(diff) == 1)
            for (int p = 0; p < 7; p++)
               if (diff[p]) return {1'b1, 3'(p + 1), n[3:0]};
      end
      return 8'd0;
   endfunction

   task automatic push_exp(input logic [6:0] cw);
      logic [7:0] m;
      m = model(cw);
      if (m[7] && exp_err < 255) exp_err++;
      exp_q.push_back({exp_err[7:0], m});
   endtask

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic send_bit(input logic b, input logic s, input logic last, output int waited);
      logic rdy;
      int   g;
      g = gap_en ? $urandom_range(0, 2) : 0;
      repeat (g) begin @(posedge clk); #1; end
      bit_valid = 1'b1; bit_in = b; sync = s;
      waited = 0;
      rdy = 1'b0;
      while (!rdy && waited < 200) begin
         @(negedge clk) rdy = bit_ready;
         @(posedge clk); #1;
         if (!rdy) waited++;
      end
      bit_valid = 1'b0; sync = 1'b0;
      if (!rdy) check("bit_accept_timeout", 16'd0, 16'd1);
      else if (last) check("latency_out_valid", 16'(out_valid), 16'd1);
   endtask

   task automatic send_word(input logic [6:0] cw);
      int w;
      push_exp(cw);
      for (int i = 6; i >= 0; i--) send_bit(cw[i], 1'b0, i == 0, w);
   endtask

   task automatic drain();
      int n;
      ready_mode = 0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin @(posedge clk); #1; n++; end
      check("drain_queue_empty", 16'(exp_q.size()), 16'd0);
   endtask

   initial forever begin
      @(posedge clk); #2;
      if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- monitor / scoreboard ----------------
   logic [8:0]  prev_out;
   logic        prev_hold = 1'b0;
   logic [15:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) check("hold_stable", 16'({out_data, out_syn, out_corr, out_valid}), 16'(prev_out));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 16'(out_data), 16'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 16'(out_data), 16'(e[3:0]));
               check("out_syn", 16'(out_syn), 16'(e[6:4]));
               check("out_corr", 16'(out_corr), 16'(e[7]));
               check("err_cnt", 16'(err_cnt), 16'(e[15:8]));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_out  = {out_data, out_syn, out_corr, out_valid};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] cw;
      logic [8:0] snap;
      logic [7:0] err_snap;
      int         w;

      #2 rst_n = 1'b0;
      #5;
      check("rst_outputs", 16'({out_data, out_syn, out_corr, out_valid}), 16'd0);
      check("rst_err_cnt", 16'(err_cnt), 16'd0);
      check("rst_bit_ready", 16'(bit_ready), 16'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end

      // Clean and single-error directed words
      out_ready = 1'b1;
      send_word(7'b0110011);
      check("clean_data", 16'(out_data), 16'd6);
      check("clean_syn", 16'(out_syn), 16'd0);
      check("clean_err", 16'(err_cnt), 16'd0);
      send_word(7'b0110010);
      check("b0err_data", 16'(out_data), 16'd6);
      check("b0err_syn", 16'(out_syn), 16'd1);
      check("b0err_err", 16'(err_cnt), 16'd1);
      send_word(7'b1101101);
      check("b6err_data", 16'(out_data), 16'd5);
      check("b6err_syn", 16'(out_syn), 16'd7);

      // Full sweep and random words with random gaps and backpressure
      gap_en = 1'b1; ready_mode = 1;
      for (int n = 0; n < 16; n++)
         for (int k = 0; k < 8; k++) begin
            cw = enc(n[3:0]);
            if (k > 0) cw = cw ^ (7'd1 << (k - 1));
            send_word(cw);
         end
      for (int i = 0; i < 40; i++) send_word(7'($urandom_range(0, 127)));
      gap_en = 1'b0;
      drain();

      // Backpressure: word 9 held, word 12 stalls on its last bit
      out_ready = 1'b0;
      send_word(enc(4'd9));
      cw = enc(4'd12);
      push_exp(cw);
      for (int i = 6; i >= 1; i--) send_bit(cw[i], 1'b0, 1'b0, w);
      check("bp_bit_ready_low", 16'(bit_ready), 16'd0);
      check("bp_hold_data", 16'(out_data), 16'd9);
      out_ready = 1'b1;
      send_bit(cw[0], 1'b0, 1'b1, w);
      check("bp_same_cycle", 16'(w), 16'd0);
      check("bp_new_data", 16'(out_data), 16'd12);
      drain();

      // Resync with a held output word
      out_ready = 1'b0;
      send_word(enc(4'd3));
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, w);
      snap = {out_data, out_syn, out_corr, out_valid};
      err_snap = err_cnt;
      send_bit(1'b1, 1'b1, 1'b0, w);
      check("sync_out_unchanged", 16'({out_data, out_syn, out_corr, out_valid}), 16'(snap));
      check("sync_err_unchanged", 16'(err_cnt), 16'(err_snap));
      out_ready = 1'b1;
      cw = 7'b1100001;
      push_exp(cw);
      for (int i = 5; i >= 0; i--) send_bit(cw[i], 1'b0, i == 0, w);
      check("sync_data", 16'(out_data), 16'd12);
      drain();

      // Reset mid-word
      send_word(enc(4'd7) ^ 7'b0000100);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, w);
      check("pre_reset_queue", 16'(exp_q.size()), 16'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", 16'({out_data, out_syn, out_corr, out_valid}), 16'd0);
      check("mid_rst_err_cnt", 16'(err_cnt), 16'd0);
      check("mid_rst_bit_ready", 16'(bit_ready), 16'd1);
      exp_q.delete();
      exp_err = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      send_word(enc(4'd10) ^ 7'b0010000);
      check("post_rst_data", 16'(out_data), 16'd10);
      check("post_rst_err", 16'(err_cnt), 16'd1);
      drain();

      // Saturation of err_cnt
      for (int i = 0; i < 260; i++)
         send_word(enc(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 6)));
      drain();
      check("sat_err_cnt", 16'(err_cnt), 16'd255);
      send_word(enc(4'd1) ^ 7'b1000000);
      drain();
      check("sat_err_stays", 16'(err_cnt), 16'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hamming_rx.md
HAMMING_RX -- requirements
Module: hamming_rx

Interface
REQ-001 Port list (name, direction, width, meaning), one SHALL per line as follows.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sync  input  1  frame resync; SHALL discard any partial word.
REQ-005 bit_in  input  1  serial codeword bit; MSB (b6) first, b0 last.
REQ-006 bit_valid  input  1  bit_in qualifier.
REQ-007 bit_ready  output  1  bit SHALL be accepted on a cycle where bit_valid && bit_ready.
REQ-008 out_data  output  4  decoded nibble {d3,d2,d1,d0}.
REQ-009 out_syn  output  3  syndrome of the emitted word.
REQ-010 out_corr  output  1  SHALL be 1 when out_syn != 0 (one bit corrected).
REQ-011 out_valid  output  1  out_* fields valid.
REQ-012 out_ready  input  1  word consumed on a cycle where out_valid && out_ready.
REQ-013 err_cnt  output  8  count of emitted words with out_corr=1.

Function
REQ-014 Codeword format: b6=d3, b5=d2, b4=d1, b3=d3^d2^d1, b2=d0, b1=d0^d2^d3, b0=d0^d1^d3. This SHALL match the team's 4-to-7 codeword table.
REQ-015 Deserialiser: a 7-bit shift register and a 3-bit bit counter (0..6).
REQ-016 Bit acceptance: each accepted bit SHALL shift in at the LSB and increment the counter.
REQ-017 Word completion: the 7th accepted bit (counter=6) SHALL complete the word and return the counter to 0.
REQ-018 Syndrome bits: s2 = b6^b5^b4^b3, s1 = b6^b5^b2^b1, s0 = b6^b4^b2^b0; syn = {s2,s1,s0}.
REQ-019 Correction: if syn != 0, bit index syn-1 SHALL be inverted before data extraction; out_data SHALL equal {b6,b5,b4,b2} of the corrected word.
REQ-020 Double errors are not detected; any nonzero syndrome SHALL be treated as a single-bit error.
REQ-021 Output register: the completed word SHALL be registered into out_data, out_syn and out_corr, with out_valid=1, on the clock edge that accepts the 7th bit.
REQ-022 Latency: the word SHALL appear one cycle after the 7th bit's acceptance cycle.
REQ-023 Output hold: out_* SHALL remain stable while out_valid && !out_ready.
REQ-024 Output clear: out_valid SHALL clear on consumption unless a new word is loaded on the same edge.
REQ-025 Backpressure: bit_ready = !(bit_cnt==6 && out_valid && !out_ready). The 7th bit SHALL be accepted only when the output slot is empty or being consumed that cycle; no word SHALL be lost or overwritten.
REQ-026 Simultaneous consume and load: the new word SHALL replace the consumed one and out_valid SHALL stay 1 (full throughput, one word per 7 bit-cycles).
REQ-027 sync=1: the counter SHALL reset to 0 and the partial word SHALL be discarded.
REQ-028 sync=1 with an accepted bit on the same cycle: that bit SHALL become b6 of the new word and the counter SHALL become 1.
REQ-029 sync SHALL not affect the output register or err_cnt.
REQ-030 err_cnt: SHALL increment by 1 per loaded word with syn != 0 and saturate at 255.
REQ-031 Gaps: bit_valid=0 cycles SHALL not disturb the counter or the shift register; gaps SHALL be allowed anywhere in a word.

Reset
REQ-032 rst_n=0 SHALL immediately clear the shift register, bit counter, out_data, out_syn, out_corr, out_valid and err_cnt to 0.
REQ-033 While rst_n=0, bit_ready SHALL be 1.
REQ-034 Reset mid-word SHALL discard the partial word; the first bit accepted after release SHALL be b6.
REQ-035 Reset release SHALL be synchronised to clk inside the block; the first accepted bit is the one on the first edge after the synchronised release.

Verification
REQ-036 Clean word: bits 0110011, out_ready=1 -> one cycle after the 7th bit: out_valid=1, out_data=6, out_syn=0, out_corr=0, err_cnt=0.
REQ-037 Single errors: 0110010 (b0 flipped) -> out_data=6, out_syn=1, out_corr=1, err_cnt=1. 1101101 (b6 of word 5 flipped) -> out_data=5, out_syn=7. Sweep all 16 nibbles x 8 error positions (none, b0..b6) -> data always correct.
REQ-038 Backpressure: out_ready=0 holding word 9, then stream word 12 -> bit_ready=0 after 6 bits accepted. Raise out_ready -> 7th bit accepted in the same cycle, word 9 consumed, then out_data=12 with out_valid continuously 1.
REQ-039 Resync: 3 bits, then sync=1 with bit_valid=1, bit=1, then 6 bits 100001 -> out_data=12 (word 1100001). Output register unchanged during the sync.
REQ-040 Reset mid-word: after 4 bits, pulse rst_n low -> all outputs 0 asynchronously; then a full 7-bit word decodes correctly.
REQ-041 Saturation: 260 words each with one error -> err_cnt=255 and stays 255.
